// File: rtl/cpu_seq_if.sv
// Control/status bundle between the debug controller and the VeriRISC run-control sequencer.
interface cpu_seq_if #(
    parameter int AWIDTH    = 5,
    parameter int CNT_WIDTH = 16
);
    logic                 run_req;
    logic                 step_req;
    logic                 stop_req;
    logic                 halt;
    logic [AWIDTH-1:0]    pc_addr;
    logic                 bp_en;
    logic [AWIDTH-1:0]    bp_addr;
    logic [2:0]           phase;
    logic                 running;
    logic                 halted;
    logic                 bp_hit;
    logic                 instr_done;
    logic [CNT_WIDTH-1:0] cycle_count;
    logic [CNT_WIDTH-1:0] instr_count;

    modport master (
        output run_req, step_req, stop_req, halt, pc_addr, bp_en, bp_addr,
        input  phase, running, halted, bp_hit, instr_done, cycle_count, instr_count
    );

    modport slave (
        input  run_req, step_req, stop_req, halt, pc_addr, bp_en, bp_addr,
        output phase, running, halted, bp_hit, instr_done, cycle_count, instr_count
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Run-control and instruction-phase sequencer for the VeriRISC core.
// state   | meaning
// IDLE    | stopped at an instruction boundary, phase held at 0
// RUN     | continuous execution, phase advances every cycle
// STEP    | executing a single instruction, then back to IDLE
// HALTED  | HLT retired; only reset leaves this state
module cpu_sequencer #(
    parameter int AWIDTH    = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    cpu_seq_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALTED} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_phase;
    logic                 r_stop_pend;
    logic                 r_bp_skip;
    logic                 r_bp_hit;
    logic [CNT_WIDTH-1:0] r_cycle_cnt;
    logic [CNT_WIDTH-1:0] r_instr_cnt;

    logic [AWIDTH-1:0]    w_pc;
    logic [AWIDTH-1:0]    w_bp_pc;
    logic                 w_active;
    logic                 w_hlt;
    logic                 w_bp;
    logic                 w_running;
    logic                 w_halted;
    logic                 w_instr_done;

    assign w_pc     = bus.pc_addr;
    assign w_bp_pc  = bus.bp_addr;
    assign w_active = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_hlt    = w_active && (r_phase == 3'd4) && bus.halt;
    assign w_bp     = (r_state == S_RUN) && (r_phase == 3'd0) && bus.bp_en &&
                      (w_pc == w_bp_pc) && !r_bp_skip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A stop request arriving in the phase-7 cycle is honoured at that same boundary.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.run_req)       w_state_nxt = S_RUN;
                else if (bus.step_req) w_state_nxt = S_STEP;
            end
            S_RUN: begin
                if (w_hlt)                  w_state_nxt = S_HALTED;
                else if (w_bp)              w_state_nxt = S_IDLE;
                else if ((r_phase == 3'd7) && (r_stop_pend || bus.stop_req))
                                            w_state_nxt = S_IDLE;
            end
            S_STEP: begin
                if (w_hlt)                  w_state_nxt = S_HALTED;
                else if (r_phase == 3'd7)   w_state_nxt = S_IDLE;
            end
            default:                        w_state_nxt = S_HALTED;
        endcase
    end

    always_comb begin
        w_running    = w_active;
        w_halted     = (r_state == S_HALTED);
        w_instr_done = w_active && ((r_phase == 3'd7) || w_hlt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= 3'd0;
            r_stop_pend <= 1'b0;
            r_bp_skip   <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (w_active && (w_state_nxt == r_state)) r_phase <= r_phase + 3'd1;
            else                                      r_phase <= 3'd0;

            if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
                if (bus.stop_req) r_stop_pend <= 1'b1;
            end else begin
                r_stop_pend <= 1'b0;
            end

            // Skip the breakpoint once after a resume so the stopped-on PC can execute.
            if ((r_state == S_IDLE) && bus.run_req)            r_bp_skip <= 1'b1;
            else if ((r_state == S_RUN) && (r_phase == 3'd0))  r_bp_skip <= 1'b0;

            if ((r_state == S_IDLE) && (bus.run_req || bus.step_req)) r_bp_hit <= 1'b0;
            else if (w_bp)                                            r_bp_hit <= 1'b1;

            if (w_active)     r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
            if (w_instr_done) r_instr_cnt <= r_instr_cnt + CNT_ONE;
        end
    end

    assign bus.phase       = r_phase;
    assign bus.running     = w_running;
    assign bus.halted      = w_halted;
    assign bus.bp_hit      = r_bp_hit;
    assign bus.instr_done  = w_instr_done;
    assign bus.cycle_count = r_cycle_cnt;
    assign bus.instr_count = r_instr_cnt;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: run/stop, step, HLT, breakpoint and reset cases.
module tb_cpu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   done_base;

    cpu_seq_if #(.AWIDTH(5), .CNT_WIDTH(16)) bus ();

    cpu_sequencer #(.AWIDTH(5), .CNT_WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst && bus.instr_done) n_done++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        done_base = n_done;
    endtask

    task automatic pulse_run();
        bus.run_req = 1'b1;
        tick();
        bus.run_req = 1'b0;
    endtask

    task automatic wait_stopped(input string tag, input int max_cyc);
        int n = 0;
        while (bus.running && n < max_cyc) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.running), 32'd0);
    endtask

    initial begin
        bus.run_req  = 1'b0;
        bus.step_req = 1'b0;
        bus.stop_req = 1'b0;
        bus.halt     = 1'b0;
        bus.pc_addr  = '0;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = '0;
        tick();
        #1;
        chk("rst_phase", 32'(bus.phase), 0);
        chk("rst_running", 32'(bus.running), 0);
        do_reset();

        // reset mid-instruction
        pulse_run();
        repeat (3) tick();
        chk("mid_phase3", 32'(bus.phase), 3);
        rst = 1'b1;
        #1;
        chk("async_phase", 32'(bus.phase), 0);
        chk("async_running", 32'(bus.running), 0);
        chk("async_cycles", 32'(bus.cycle_count), 0);
        chk("async_instrs", 32'(bus.instr_count), 0);
        chk("async_halted", 32'(bus.halted), 0);
        rst = 1'b0;
        done_base = n_done;

        // three instructions, stop requested at phase 2 of the third
        pulse_run();
        repeat (18) tick();
        chk("run_phase2", 32'(bus.phase), 2);
        bus.stop_req = 1'b1;
        tick();
        bus.stop_req = 1'b0;
        chk("run_pending", 32'(bus.running), 1);
        wait_stopped("run_stop_timeout", 20);
        chk("run_instrs", 32'(bus.instr_count), 3);
        chk("run_cycles", 32'(bus.cycle_count), 24);
        chk("run_done_pulses", 32'(n_done - done_base), 3);
        chk("run_idle_phase", 32'(bus.phase), 0);

        // single step
        do_reset();
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("step_phase", 32'(bus.phase), 32'(i));
            chk("step_done", 32'(bus.instr_done), (i == 7) ? 32'd1 : 32'd0);
            tick();
        end
        chk("step_running", 32'(bus.running), 0);
        chk("step_instrs", 32'(bus.instr_count), 1);
        chk("step_cycles", 32'(bus.cycle_count), 8);

        // HLT in the second instruction; a stray halt at phase 2 must be ignored
        do_reset();
        pulse_run();
        repeat (2) tick();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        chk("hlt_ignored_run", 32'(bus.running), 1);
        chk("hlt_ignored_phase", 32'(bus.phase), 3);
        repeat (9) tick();
        chk("hlt_phase4", 32'(bus.phase), 4);
        bus.halt = 1'b1;
        #1;
        chk("hlt_done", 32'(bus.instr_done), 1);
        tick();
        bus.halt = 1'b0;
        chk("hlt_halted", 32'(bus.halted), 1);
        chk("hlt_running", 32'(bus.running), 0);
        chk("hlt_phase", 32'(bus.phase), 0);
        chk("hlt_instrs", 32'(bus.instr_count), 2);
        chk("hlt_cycles", 32'(bus.cycle_count), 13);
        pulse_run();
        tick();
        chk("hlt_run_ignored", 32'(bus.running), 0);
        chk("hlt_sticky", 32'(bus.halted), 1);

        // breakpoint at PC 5, resume past it, stop at phase 7
        do_reset();
        bus.bp_en   = 1'b1;
        bus.bp_addr = 5'd5;
        bus.pc_addr = 5'd3;
        pulse_run();
        repeat (8) tick();
        bus.pc_addr = 5'd4;
        repeat (8) tick();
        bus.pc_addr = 5'd5;
        chk("bp_pre_hit", 32'(bus.bp_hit), 0);
        tick();
        chk("bp_hit", 32'(bus.bp_hit), 1);
        chk("bp_running", 32'(bus.running), 0);
        chk("bp_phase", 32'(bus.phase), 0);
        chk("bp_cycles", 32'(bus.cycle_count), 17);
        chk("bp_instrs", 32'(bus.instr_count), 2);
        pulse_run();
        chk("bp_clear", 32'(bus.bp_hit), 0);
        chk("bp_resume_run", 32'(bus.running), 1);
        tick();
        chk("bp_no_rehit", 32'(bus.running), 1);
        chk("bp_resume_phase", 32'(bus.phase), 1);
        repeat (6) tick();
        chk("bp_phase7_done", 32'(bus.instr_done), 1);
        bus.stop_req = 1'b1;
        tick();
        bus.stop_req = 1'b0;
        chk("stop7_running", 32'(bus.running), 0);
        chk("stop7_instrs", 32'(bus.instr_count), 3);
        bus.bp_en = 1'b0;

        // run and step together: run wins and keeps going past the boundary
        do_reset();
        bus.run_req  = 1'b1;
        bus.step_req = 1'b1;
        tick();
        bus.run_req  = 1'b0;
        bus.step_req = 1'b0;
        chk("both_running", 32'(bus.running), 1);
        repeat (8) tick();
        chk("both_still_run", 32'(bus.running), 1);
        chk("both_instrs", 32'(bus.instr_count), 1);
        bus.stop_req = 1'b1;
        tick();
        bus.stop_req = 1'b0;
        wait_stopped("both_stop_timeout", 20);
        chk("both_stop_instrs", 32'(bus.instr_count), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
